// File: rtl/clk_div_pkg.sv
// ---------------------------------------------------------------------------
// clk_div_pkg
// Shared definitions for the clock divider run-time controller.
//   state_t          : controller FSM encodings (OFF/RUN/DRAIN/GATE/LOAD)
//   RATIO_W_DEF      : default ratio bus width
//   RESET_RATIO_DEF  : default ratio driven while in and after reset
// ---------------------------------------------------------------------------
package clk_div_pkg;

    localparam int RATIO_W_DEF     = 8;
    localparam int RESET_RATIO_DEF = 10;

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_GATE  = 3'd3,
        ST_LOAD  = 3'd4
    } state_t;

endpackage

// File: rtl/clk_div_ctrl_if.sv
// ---------------------------------------------------------------------------
// clk_div_ctrl_if
// Ratio configuration handshake between the config register block (master)
// and the controller (slave).
//   cfg_valid : master offers a ratio
//   cfg_ratio : offered ratio, captured when cfg_valid && cfg_ready
//   cfg_ready : slave can accept a ratio this cycle
// Handshake: a transfer happens on a rising edge where cfg_valid and
// cfg_ready are both 1. While cfg_ready is 0 the master keeps the offer
// (valid and ratio) stable; the slave never captures and never flags an
// error for a cycle without cfg_ready.
// ---------------------------------------------------------------------------
interface clk_div_ctrl_if #(
    parameter int RATIO_W = 8
);
    logic               cfg_valid;
    logic [RATIO_W-1:0] cfg_ratio;
    logic               cfg_ready;

    modport master (output cfg_valid, output cfg_ratio, input  cfg_ready);
    modport slave  (input  cfg_valid, input  cfg_ratio, output cfg_ready);
endinterface

// File: rtl/clk_div_ctrl_timer.sv
// ---------------------------------------------------------------------------
// clk_div_ctrl_timer
// Clearable saturating up-counter with a terminal-count flag. One instance is
// shared by the DRAIN timeout and the GATE hold time; the parent selects the
// terminal value according to the current state.
// Ports:
//   clk      in  1  clock (rising edge)
//   rst      in  1  asynchronous, active-low reset
//   clear    in  1  synchronous clear (count <= 0 on next edge)
//   tc_value in  W  terminal value to compare against
//   count    out W  current count
//   tc       out 1  count == tc_value
// ---------------------------------------------------------------------------
module clk_div_ctrl_timer #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic [W-1:0] tc_value,
    output logic [W-1:0] count,
    output logic         tc
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count != {W{1'b1}}) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == tc_value);

endmodule

// File: rtl/clk_div_ctrl.sv
// ---------------------------------------------------------------------------
// clk_div_ctrl
// Run-time controller for the programmable clock divider. Owns the divider's
// enable and ratio inputs. Ratio updates arrive over a valid/ready handshake;
// before every ratio change while running, the controller waits for the
// divided clock to be low (or a timeout), gates the divider for GATE_CYCLES,
// loads the new ratio and re-enables if still requested.
// Optional feature macro: CLK_DIV_CTRL_RATIO_CHECK_EN -- when defined, ratios
// below 2 are accepted on the handshake but discarded, with a one-cycle
// o_cfg_err pulse. When undefined every ratio passes and o_cfg_err is 0.
// Ports:
//   ref_clk     in   1        reference clock, rising edge
//   rst         in   1        asynchronous, active-low reset
//   i_enable    in   1        level request for the divided clock
//   cfg         slave         ratio handshake (cfg_valid/cfg_ratio/cfg_ready)
//   div_clk_fb  in   1        divider output fed back (same domain)
//   o_clk_en    out  1        registered enable to divider
//   o_div_ratio out  RATIO_W  registered ratio to divider
//   o_busy      out  1        high in DRAIN/GATE/LOAD
//   o_cfg_err   out  1        one-cycle pulse on rejected ratio
//   dbg_state   out  state_t  current FSM state
// ---------------------------------------------------------------------------
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int RATIO_W     = RATIO_W_DEF,
    parameter int RESET_RATIO = RESET_RATIO_DEF,
    parameter int GATE_CYCLES = 2,
    parameter int TIMEOUT     = 512
) (
    input  logic               ref_clk,
    input  logic               rst,
    input  logic               i_enable,
    clk_div_ctrl_if.slave      cfg,
    input  logic               div_clk_fb,
    output logic               o_clk_en,
    output logic [RATIO_W-1:0] o_div_ratio,
    output logic               o_busy,
    output logic               o_cfg_err,
    output state_t             dbg_state
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [RATIO_W-1:0] RST_RATIO = RATIO_W'(RESET_RATIO);

    state_t             state, state_n;
    logic               pend_v, pend_v_n;
    logic [RATIO_W-1:0] pend_r, pend_r_n;
    logic [RATIO_W-1:0] ratio_n;
    logic               clk_en_n;
    logic               cfg_err_n;
    logic               hs;
    logic               ratio_ok;
    logic               take;
    logic [TW-1:0]      tmr_count;
    logic [TW-1:0]      tmr_tc_value;
    logic               tmr_tc;
    logic               tmr_clear;

    assign cfg.cfg_ready = (state == ST_OFF) || (state == ST_RUN);
    assign o_busy        = (state == ST_DRAIN) || (state == ST_GATE) || (state == ST_LOAD);
    assign dbg_state     = state;

    assign hs = cfg.cfg_valid && cfg.cfg_ready;

`ifdef CLK_DIV_CTRL_RATIO_CHECK_EN
    assign ratio_ok = (cfg.cfg_ratio >= RATIO_W'(2));
`else
    assign ratio_ok = 1'b1;
`endif

    // A rejected ratio still completes the handshake but is otherwise ignored.
    assign take = hs && ratio_ok;

    // Timer restarts on every state change so each state sees count 0 first.
    assign tmr_clear    = (state_n != state);
    assign tmr_tc_value = (state == ST_DRAIN) ? TW'(TIMEOUT - 1) : TW'(GATE_CYCLES - 1);

    clk_div_ctrl_timer #(.W(TW)) u_timer (
        .clk      (ref_clk),
        .rst      (rst),
        .clear    (tmr_clear),
        .tc_value (tmr_tc_value),
        .count    (tmr_count),
        .tc       (tmr_tc)
    );

    always_comb begin
        state_n   = state;
        pend_v_n  = pend_v;
        pend_r_n  = pend_r;
        ratio_n   = o_div_ratio;
        cfg_err_n = 1'b0;
`ifdef CLK_DIV_CTRL_RATIO_CHECK_EN
        cfg_err_n = hs && !ratio_ok;
`endif
        case (state)
            ST_OFF: begin
                // Divider is gated, so the ratio can be loaded directly.
                if (take) ratio_n = cfg.cfg_ratio;
                if (i_enable) state_n = ST_RUN;
            end
            ST_RUN: begin
                if (take) begin
                    pend_r_n = cfg.cfg_ratio;
                    pend_v_n = 1'b1;
                    state_n  = ST_DRAIN;
                end else if (!i_enable) begin
                    state_n = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!div_clk_fb || tmr_tc) state_n = ST_GATE;
            end
            ST_GATE: begin
                if (tmr_tc) state_n = ST_LOAD;
            end
            ST_LOAD: begin
                if (pend_v) ratio_n = pend_r;
                pend_v_n = 1'b0;
                state_n  = i_enable ? ST_RUN : ST_OFF;
            end
            default: begin
                state_n = ST_OFF;
            end
        endcase
        // Enable is a registered decode of the state being entered.
        clk_en_n = (state_n == ST_RUN) || (state_n == ST_DRAIN);
    end

    always_ff @(posedge ref_clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_OFF;
            pend_v      <= 1'b0;
            pend_r      <= '0;
            o_clk_en    <= 1'b0;
            o_div_ratio <= RST_RATIO;
            o_cfg_err   <= 1'b0;
        end else begin
            state       <= state_n;
            pend_v      <= pend_v_n;
            pend_r      <= pend_r_n;
            o_clk_en    <= clk_en_n;
            o_div_ratio <= ratio_n;
            o_cfg_err   <= cfg_err_n;
        end
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clk_div_ctrl
// Directed bench for clk_div_ctrl (GATE_CYCLES=2, TIMEOUT=512, RESET_RATIO=10).
// Inputs are driven and outputs sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_clk_div_ctrl;
    import clk_div_pkg::*;

    logic       ref_clk;
    logic       rst;
    logic       i_enable;
    logic       div_clk_fb;
    logic       o_clk_en;
    logic [7:0] o_div_ratio;
    logic       o_busy;
    logic       o_cfg_err;
    state_t     dbg_state;

    int n_total;
    int n_pass;

    clk_div_ctrl_if #(.RATIO_W(8)) cfg_bus ();

    clk_div_ctrl #(
        .RATIO_W     (8),
        .RESET_RATIO (10),
        .GATE_CYCLES (2),
        .TIMEOUT     (512)
    ) dut (
        .ref_clk     (ref_clk),
        .rst         (rst),
        .i_enable    (i_enable),
        .cfg         (cfg_bus),
        .div_clk_fb  (div_clk_fb),
        .o_clk_en    (o_clk_en),
        .o_div_ratio (o_div_ratio),
        .o_busy      (o_busy),
        .o_cfg_err   (o_cfg_err),
        .dbg_state   (dbg_state)
    );

    // clock
    initial ref_clk = 1'b0;
    always #5 ref_clk = ~ref_clk;

    task automatic tick();
        @(posedge ref_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic offer(input logic [7:0] r);
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_ratio = r;
    endtask

    task automatic no_offer();
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_ratio = 8'd0;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst = 1'b0;
        i_enable = 1'b0;
        div_clk_fb = 1'b0;
        no_offer();

        // reset state
        ticks(2);
        chk("rst_clk_en", 32'(o_clk_en), 32'd0);
        chk("rst_ratio", 32'(o_div_ratio), 32'd10);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_ready", 32'(cfg_bus.cfg_ready), 32'd1);
        chk("rst_err", 32'(o_cfg_err), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(ST_OFF));
        rst = 1'b1;
        tick();

        // 1: enable from OFF
        i_enable = 1'b1;
        tick();
        chk("t1_clk_en", 32'(o_clk_en), 32'd1);
        chk("t1_ratio", 32'(o_div_ratio), 32'd10);
        chk("t1_busy", 32'(o_busy), 32'd0);
        chk("t1_state", 32'(dbg_state), 32'(ST_RUN));

        // 2: ratio 4 with feedback already low
        offer(8'd4);
        tick();
        no_offer();
        chk("t2_drain_state", 32'(dbg_state), 32'(ST_DRAIN));
        chk("t2_drain_en", 32'(o_clk_en), 32'd1);
        chk("t2_drain_busy", 32'(o_busy), 32'd1);
        chk("t2_drain_ready", 32'(cfg_bus.cfg_ready), 32'd0);
        tick();
        chk("t2_gate0_en", 32'(o_clk_en), 32'd0);
        chk("t2_gate0_state", 32'(dbg_state), 32'(ST_GATE));
        tick();
        chk("t2_gate1_en", 32'(o_clk_en), 32'd0);
        chk("t2_gate1_ratio", 32'(o_div_ratio), 32'd10);
        tick();
        chk("t2_load_state", 32'(dbg_state), 32'(ST_LOAD));
        chk("t2_load_ratio", 32'(o_div_ratio), 32'd10);
        tick();
        chk("t2_ratio", 32'(o_div_ratio), 32'd4);
        chk("t2_en", 32'(o_clk_en), 32'd1);
        chk("t2_state", 32'(dbg_state), 32'(ST_RUN));

        // 3: feedback stuck high -> drain timeout after 512 cycles
        div_clk_fb = 1'b1;
        offer(8'd6);
        tick();
        no_offer();
        ticks(511);
        chk("t3_drain_last_state", 32'(dbg_state), 32'(ST_DRAIN));
        chk("t3_drain_last_en", 32'(o_clk_en), 32'd1);
        chk("t3_drain_ratio", 32'(o_div_ratio), 32'd4);
        tick();
        chk("t3_gate_state", 32'(dbg_state), 32'(ST_GATE));
        chk("t3_gate_en", 32'(o_clk_en), 32'd0);
        div_clk_fb = 1'b0;
        ticks(3);
        chk("t3_ratio", 32'(o_div_ratio), 32'd6);
        chk("t3_state", 32'(dbg_state), 32'(ST_RUN));

        // 4: ratio 8 and disable in the same cycle
        offer(8'd8);
        i_enable = 1'b0;
        tick();
        no_offer();
        chk("t4_drain_state", 32'(dbg_state), 32'(ST_DRAIN));
        ticks(4);
        chk("t4_ratio", 32'(o_div_ratio), 32'd8);
        chk("t4_en", 32'(o_clk_en), 32'd0);
        chk("t4_state", 32'(dbg_state), 32'(ST_OFF));
        chk("t4_ready", 32'(cfg_bus.cfg_ready), 32'd1);

        // OFF: ratio and enable together
        offer(8'd5);
        i_enable = 1'b1;
        tick();
        no_offer();
        chk("off_ratio", 32'(o_div_ratio), 32'd5);
        chk("off_en", 32'(o_clk_en), 32'd1);
        chk("off_state", 32'(dbg_state), 32'(ST_RUN));

        // offer held while busy is not captured until ready returns
        offer(8'd3);
        tick();
        cfg_bus.cfg_ratio = 8'd7;
        ticks(3);
        chk("hold_load_ratio", 32'(o_div_ratio), 32'd5);
        tick();
        chk("hold_ratio3", 32'(o_div_ratio), 32'd3);
        chk("hold_run_state", 32'(dbg_state), 32'(ST_RUN));
        tick();
        no_offer();
        chk("hold_recapture", 32'(dbg_state), 32'(ST_DRAIN));
        ticks(4);
        chk("hold_ratio7", 32'(o_div_ratio), 32'd7);

        // 6: ratio 1 in RUN
        offer(8'd1);
        tick();
        no_offer();
`ifdef CLK_DIV_CTRL_RATIO_CHECK_EN
        chk("t6_err", 32'(o_cfg_err), 32'd1);
        chk("t6_state", 32'(dbg_state), 32'(ST_RUN));
        chk("t6_ratio", 32'(o_div_ratio), 32'd7);
        tick();
        chk("t6_err_end", 32'(o_cfg_err), 32'd0);
`else
        chk("t6_err", 32'(o_cfg_err), 32'd0);
        chk("t6_state", 32'(dbg_state), 32'(ST_DRAIN));
        ticks(4);
        chk("t6_ratio", 32'(o_div_ratio), 32'd1);
`endif

        // 5: reset asserted in GATE
        offer(8'd9);
        tick();
        no_offer();
        tick();
        chk("t5_gate_state", 32'(dbg_state), 32'(ST_GATE));
        rst = 1'b0;
        #1;
        chk("t5_rst_en", 32'(o_clk_en), 32'd0);
        chk("t5_rst_ratio", 32'(o_div_ratio), 32'd10);
        chk("t5_rst_state", 32'(dbg_state), 32'(ST_OFF));
        tick();
        rst = 1'b1;
        chk("t5_ready", 32'(cfg_bus.cfg_ready), 32'd1);
        tick();
        chk("t5_run_state", 32'(dbg_state), 32'(ST_RUN));
        ticks(5);
        chk("t5_pending_lost", 32'(o_div_ratio), 32'd10);
        chk("t5_busy", 32'(o_busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
